// File: rtl/rst_req_ctrl.sv
// rtl/rst_req_ctrl.sv - reset request sequencer with hold timer and sticky cause capture
// Rising edges on req_i start one handshaked low pulse on rst_req_no; cause_o records every edge.
module rst_req_ctrl #(
  parameter int NUM_SRC     = 3,
  parameter int HOLD_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic               sys_rst_ni,
  input  logic               cause_clr_i,
  output logic               rst_req_no,
  output logic [NUM_SRC-1:0] cause_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rst_req_q, rst_req_d;
  logic               busy_q, busy_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [NUM_SRC-1:0] req_prev_q;
  logic               ack_meta_q, ack_q;
  logic [NUM_SRC-1:0] trig;

  // The downstream reset deasserts synchronously to its own domain, so it is re-synced here.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_meta_q <= 1'b1;
      ack_q      <= 1'b1;
    end else begin
      ack_meta_q <= sys_rst_ni;
      ack_q      <= ack_meta_q;
    end
  end

  // All-ones reset keeps requests already high at power-on from triggering.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      req_prev_q <= '1;
    end else begin
      req_prev_q <= req_i;
    end
  end

  assign trig = req_i & ~req_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|trig) begin
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (!ack_q) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (ack_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    rst_req_d = !((state_d == ST_ASSERT) || (state_d == ST_HOLD));
    busy_d    = (state_d != ST_IDLE);

    cause_d = cause_q;
    if ((state_q == ST_IDLE) && cause_clr_i) begin
      cause_d = '0;
    end
    cause_d = cause_d | trig;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rst_req_q <= 1'b1;
      busy_q    <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_req_q <= rst_req_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
    end
  end

  assign rst_req_no = rst_req_q;
  assign busy_o     = busy_q;
  assign cause_o    = cause_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// tb/tb_rst_req_ctrl.sv - scoreboard bench for rst_req_ctrl with a looped-back downstream reset
// Stimulus queues the expected pulse timing; a negedge monitor measures each pulse and compares.
module tb_rst_req_ctrl;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       clr = 1'b0;
  logic       sys_force = 1'b0;
  logic       lb = 1'b1;
  logic       sys_rst_n;
  logic       rst_req_n;
  logic [2:0] cause;
  logic       busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         fall;
    int         rise;
    int         idle;
    logic [2:0] cause;
  } exp_t;

  exp_t exp_q[$];

  bit seen_fall = 1'b0;
  bit seen_rise = 1'b0;
  int fall_c = 0;
  int rise_c = 0;

  rst_req_ctrl #(
    .NUM_SRC    (3),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk        (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .sys_rst_ni (sys_rst_n),
    .cause_clr_i(clr),
    .rst_req_no (rst_req_n),
    .cause_o    (cause),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream synchronizer model: follows rst_req_no one cycle late unless held high.
  always @(posedge clk) lb <= rst_req_n;
  assign sys_rst_n = sys_force ? 1'b1 : lb;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      seen_fall = 1'b0;
      seen_rise = 1'b0;
    end else begin
      if (!seen_fall && !rst_req_n) begin
        seen_fall = 1'b1;
        fall_c    = cyc;
      end
      if (seen_fall && !seen_rise && rst_req_n) begin
        seen_rise = 1'b1;
        rise_c    = cyc;
      end
      if (seen_fall && !busy) begin
        if (exp_q.size() == 0) begin
          cmp("unexpected_pulse", fall_c, -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          cmp("pulse_fall_cycle", fall_c, e.fall);
          cmp("pulse_rise_cycle", rise_c, e.rise);
          cmp("pulse_idle_cycle", cyc, e.idle);
          cmp("pulse_cause", int'(cause), int'(e.cause));
        end
        seen_fall = 1'b0;
        seen_rise = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    if (busy) cmp("idle_timeout", 1, 0);
  endtask

  // Drive a request edge now (cycle T) and queue the timing the loopback produces.
  task automatic pulse(input logic [2:0] bits, input logic [2:0] exp_cause);
    exp_t e;
    req     = bits;
    e.fall  = cyc + 1;
    e.rise  = cyc + 5 + HOLD;
    e.idle  = cyc + 9 + HOLD;
    e.cause = exp_cause;
    exp_q.push_back(e);
  endtask

  task automatic clear_cause();
    clr = 1'b1;
    step();
    clr = 1'b0;
    cmp("cause_clr_idle", int'(cause), 0);
  endtask

  initial begin
    int bad;
    int r;
    exp_t e;

    req = 3'b111;
    step();
    cmp("reset_rst_req_no", int'(rst_req_n), 1);
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_cause", int'(cause), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    cmp("powerup_level_no_cause", int'(cause), 0);
    cmp("powerup_level_no_busy", int'(busy), 0);
    req = 3'b000;
    while (cyc < 10) step();

    // Watchdog source edge at cycle 10: low 11..18, high 19, idle 23.
    pulse(3'b010, 3'b010);
    step();
    wait_idle();
    req = 3'b000;
    step();
    clear_cause();

    // Level held high: one pulse only, then a fresh edge gives a second pulse.
    pulse(3'b001, 3'b001);
    step();
    wait_idle();
    repeat (10) step();
    req = 3'b000;
    step();
    pulse(3'b001, 3'b001);
    step();
    wait_idle();
    req = 3'b000;
    step();
    clear_cause();

    // Debug edge during HOLD is only recorded.
    pulse(3'b001, 3'b101);
    repeat (6) step();
    req = 3'b101;
    step();
    wait_idle();
    req = 3'b000;
    step();
    clear_cause();

    // Clear ignored in HOLD, honoured in IDLE, and loses to a coincident edge.
    pulse(3'b001, 3'b001);
    repeat (6) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    cmp("cause_clr_in_hold", int'(cause), 1);
    wait_idle();
    req = 3'b000;
    step();
    clr = 1'b1;
    pulse(3'b010, 3'b010);
    step();
    clr = 1'b0;
    cmp("cause_set_wins", int'(cause), 2);
    wait_idle();
    req = 3'b000;
    step();
    clear_cause();

    // Acknowledge withheld for 50 cycles: the FSM must sit in ASSERT.
    sys_force = 1'b1;
    req = 3'b100;
    e.fall = cyc + 1;
    step();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (rst_req_n !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    cmp("stuck_in_assert", bad, 0);
    r = cyc;
    e.rise  = r + 3 + HOLD;
    e.idle  = r + 7 + HOLD;
    e.cause = 3'b100;
    exp_q.push_back(e);
    sys_force = 1'b0;
    step();
    wait_idle();
    req = 3'b000;
    step();

    // Power-on reset in HOLD aborts at once; the held request must not retrigger.
    req = 3'b001;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    cmp("abort_rst_req_no", int'(rst_req_n), 1);
    cmp("abort_busy", int'(busy), 0);
    cmp("abort_cause", int'(cause), 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    cmp("post_abort_busy", int'(busy), 0);
    cmp("post_abort_rst_req_no", int'(rst_req_n), 1);
    cmp("post_abort_cause", int'(cause), 0);

    cmp("scoreboard_drained", exp_q.size(), 0);
    cmp("no_open_pulse", int'(seen_fall), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rst_req_ctrl.md
RST_REQ_CTRL -- requirements
Module: rst_req_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of reset-request sources; legal range 1..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: minimum cycles the request is held after acknowledge; legal value >=1.
REQ-003 SHALL have port clk, input, width 1: clock.
REQ-004 SHALL have port rst_ni, input, width 1: reset, asynchronous, active-low; power-on reset only, never driven by rst_req_no.
REQ-005 SHALL have port req_i, input, width NUM_SRC: level reset requests (bit0 sw, bit1 wdt, bit2 dbg), synchronous to clk.
REQ-006 SHALL have port sys_rst_ni, input, width 1: system reset fed back from the downstream synchronizer; asynchronous assert, synchronous deassert.
REQ-007 SHALL have port cause_clr_i, input, width 1: single-cycle clear of cause_o.
REQ-008 SHALL have port rst_req_no, output, width 1: active-low reset request to the downstream synchronizer.
REQ-009 SHALL have port cause_o, output, width NUM_SRC: sticky record of sources that requested reset.
REQ-010 SHALL have port busy_o, output, width 1: high whenever state is not IDLE.

Function
REQ-011 SHALL pass sys_rst_ni through a 2-flop synchronizer (reset value 1) before any use; all references below to "ack" mean the synchronized value.
REQ-012 SHALL detect triggers as rising edges of req_i (req_i high, registered previous value low); the previous-value register resets to all-ones so requests already high at power-on do not trigger.
REQ-013 SHALL implement FSM states IDLE, ASSERT, HOLD, RELEASE, all outputs registered.
REQ-014 IDLE: on any trigger bit in cycle N, SHALL enter ASSERT at N+1 with rst_req_no=0 in cycle N+1.
REQ-015 ASSERT: rst_req_no=0; SHALL move to HOLD the cycle after synchronized ack is sampled 0, loading the down-counter with HOLD_CYCLES-1.
REQ-016 HOLD: rst_req_no=0; counter decrements each cycle; at counter==0 SHALL move to RELEASE, so HOLD lasts exactly HOLD_CYCLES cycles.
REQ-017 RELEASE: rst_req_no=1; SHALL return to IDLE the cycle after synchronized ack is sampled 1.
REQ-018 No timeout in ASSERT or RELEASE; the FSM waits indefinitely for ack.
REQ-019 Counter width SHALL be $clog2(HOLD_CYCLES+1) bits; no wrap, it is reloaded on every HOLD entry.
REQ-020 Triggers occurring outside IDLE SHALL NOT restart or extend the sequence; they are only recorded in cause_o.
REQ-021 A trigger in the same cycle the FSM returns from RELEASE to IDLE SHALL be ignored for sequencing; a request level still high in IDLE does not retrigger.
REQ-022 cause_o SHALL OR in every trigger bit in any state, one cycle after the edge.
REQ-023 cause_clr_i SHALL clear cause_o to 0 only in IDLE; it is ignored in other states.
REQ-024 A simultaneous trigger and cause_clr_i SHALL leave only the new trigger bits set (set wins).
REQ-025 busy_o SHALL equal (state != IDLE), registered with the state.

Reset
REQ-026 On rst_ni low, SHALL asynchronously go to state IDLE with rst_req_no=1, busy_o=0, cause_o=0, counter=0, ack synchronizer=11, and req_i-previous=all-ones.
REQ-027 rst_ni asserted mid-sequence SHALL abort immediately; after release the block stays in IDLE until a fresh req_i rising edge.

Verification (NUM_SRC=3, HOLD_CYCLES=4)
REQ-028 Scenario: req_i 000->010 at cycle 10, sys_rst_ni looped to follow rst_req_no with 1-cycle delay -> rst_req_no low from cycle 11, HOLD entered at cycle 15, rst_req_no high at cycle 19, IDLE when ack returns high, cause_o=010.
REQ-029 Scenario: req_i=001 held high through and after the sequence -> exactly one reset pulse; a second 0->1 edge afterwards -> a second pulse; cause_o=001.
REQ-030 Scenario: bit2 edge during HOLD -> pulse length unchanged at 4 HOLD cycles, cause_o becomes 101 (after bit0 trigger).
REQ-031 Scenario: sys_rst_ni held high for 50 cycles after the request -> FSM remains in ASSERT, rst_req_no=0, busy_o=1 throughout.
REQ-032 Scenario: cause_clr_i pulse in HOLD -> cause_o unchanged; pulse in IDLE -> 000; pulse coincident with bit1 edge in IDLE -> 010.
REQ-033 Scenario: rst_ni low during HOLD -> same cycle rst_req_no=1, busy_o=0, cause_o=000; no pulse after release while req_i stays high.
